uram_req_ctrl: RTL and testbench

- Request/response front end for the banked URAM array (port A or port B, one instance per port).
- Accepts valid/ready read and write requests, drives the array's registered port signals, and tracks the fixed read latency with a shift register.
- Buffers returned read data in a credit-guarded response FIFO, so a stalled consumer never loses data.

---
 rtl/uram_req_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uram_req_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uram_req_ctrl.sv
// Valid/ready request front end for one URAM port: registers the array port signals,
// tracks the fixed read latency and buffers read data in a credit-guarded response FIFO.
module uram_req_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_wr,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [8:0]                     req_bwe,
  input  logic [71:0]                    req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [71:0]                    rsp_data,
  output logic                           URAM_EN,
  output logic                           URAM_RDB_WR,
  output logic [22:0]                    URAM_ADDR,
  output logic [8:0]                     URAM_BWE,
  output logic [71:0]                    URAM_DIN,
  input  logic [71:0]                    URAM_DOUT,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rd_outstanding
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic              r_en;
  logic              r_rdb_wr;
  logic [22:0]       r_addr;
  logic [8:0]        r_bwe;
  logic [71:0]       r_din;
  logic [RD_LAT-1:0] r_lat;
  logic [71:0]       r_mem [RSP_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_outstanding;
  logic              r_rsp_valid;
  logic [71:0]       r_rsp_data;

  logic              w_accept;
  logic              w_rd_accept;
  logic              w_lat_in;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_wptr_inc;
  logic [PW-1:0]     w_rptr_inc;
  logic [CW-1:0]     w_count_next;
  logic [71:0]       w_head_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check only gates reads; writes never need a response slot.
  assign req_ready   = !rst && (req_wr || (r_outstanding != CW'(RSP_DEPTH)));
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_rdb_wr <= 1'b0;
      r_addr   <= '0;
      r_bwe    <= '0;
      r_din    <= '0;
    end else begin
      r_en     <= w_accept;
      r_rdb_wr <= w_accept && req_wr;
      r_bwe    <= (w_accept && req_wr) ? req_bwe : '0;
      if (w_accept) begin
        r_addr <= 23'(req_addr);
        r_din  <= req_wr ? req_data : '0;
      end
    end
  end

  // Bit 0 is set by a read currently on the array port; the top bit marks DOUT valid.
  assign w_lat_in = r_en && !r_rdb_wr;
  assign w_push   = r_lat[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat <= '0;
    end else begin
      r_lat[0] <= w_lat_in;
      for (int i = 1; i < RD_LAT; i++) begin
        r_lat[i] <= r_lat[i-1];
      end
    end
  end

  assign w_pop      = r_rsp_valid && rsp_ready;
  assign w_wptr_inc = ptr_inc(r_wptr);
  assign w_rptr_inc = ptr_inc(r_rptr);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Head register bypasses DOUT when the incoming word becomes the new head.
  always_comb begin
    w_head_next = r_rsp_data;
    if (w_pop) begin
      if (r_count == CW'(1)) begin
        if (w_push) begin
          w_head_next = URAM_DOUT;
        end
      end else begin
        w_head_next = r_mem[w_rptr_inc];
      end
    end else if (w_push && (r_count == '0)) begin
      w_head_next = URAM_DOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= URAM_DOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= w_wptr_inc;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end
      r_count     <= w_count_next;
      r_rsp_valid <= (w_count_next != '0);
      r_rsp_data  <= w_head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (w_rd_accept && !w_pop) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_rd_accept && w_pop) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  assign URAM_EN        = r_en;
  assign URAM_RDB_WR    = r_rdb_wr;
  assign URAM_ADDR      = r_addr;
  assign URAM_BWE       = r_bwe;
  assign URAM_DIN       = r_din;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rd_outstanding = r_outstanding;

endmodule

// File: tb/tb_uram_req_ctrl.sv
// Directed and random bench for uram_req_ctrl with a behavioural two-cycle URAM model,
// a reference memory and an in-order response scoreboard.
module tb_uram_req_ctrl;

  localparam int ADDR_W    = 16;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 4;
  localparam int CW        = $clog2(RSP_DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [8:0]        req_bwe;
  logic [71:0]       req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [71:0]       rsp_data;
  logic              URAM_EN;
  logic              URAM_RDB_WR;
  logic [22:0]       URAM_ADDR;
  logic [8:0]        URAM_BWE;
  logic [71:0]       URAM_DIN;
  logic [71:0]       URAM_DOUT;
  logic [CW-1:0]     rd_outstanding;

  uram_req_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_bwe(req_bwe), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .URAM_EN(URAM_EN), .URAM_RDB_WR(URAM_RDB_WR), .URAM_ADDR(URAM_ADDR),
    .URAM_BWE(URAM_BWE), .URAM_DIN(URAM_DIN), .URAM_DOUT(URAM_DOUT),
    .rd_outstanding(rd_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: input register stage, then read/write one cycle later (write-first).
  logic [71:0] arr [int];
  logic        a_en, a_wr;
  logic [22:0] a_addr;
  logic [8:0]  a_bwe;
  logic [71:0] a_din;

  always @(posedge clk) begin : array_model
    logic [71:0] w;
    a_en   <= URAM_EN;
    a_wr   <= URAM_RDB_WR;
    a_addr <= URAM_ADDR;
    a_bwe  <= URAM_BWE;
    a_din  <= URAM_DIN;
    if (a_en === 1'b1) begin
      w = arr.exists(int'(a_addr)) ? arr[int'(a_addr)] : '0;
      if (a_wr) begin
        for (int b = 0; b < 9; b++) if (a_bwe[b]) w[b*8 +: 8] = a_din[b*8 +: 8];
        arr[int'(a_addr)] = w;
      end else begin
        URAM_DOUT <= w;
      end
    end
  end

  logic [71:0] ref_mem [int];
  logic [71:0] exp_q [$];
  int          errors, checks, cyc, exp_out;
  int          rd_acc_cyc, acc_cnt, pop_cnt, first_pop, last_pop, max_gap;
  logic [71:0] last_pop_data;
  bit          rnd_rdy;

  function automatic logic [71:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle at the falling edge: checks live state, then models the coming edge.
  task automatic monitor();
    logic [71:0] w;
    check("rd_outstanding", 72'(rd_outstanding), 72'(exp_out));
    check("rd_outstanding_max", 72'(rd_outstanding <= CW'(RSP_DEPTH)), 72'(1));
    check("req_ready", 72'(req_ready), 72'(!rst && (req_wr || exp_out < RSP_DEPTH)));
    if (rst) begin
      exp_q.delete();
      exp_out = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cnt++;
        if (req_wr) begin
          w = ref_rd(req_addr);
          for (int b = 0; b < 9; b++) if (req_bwe[b]) w[b*8 +: 8] = req_data[b*8 +: 8];
          ref_mem[int'(req_addr)] = w;
        end else begin
          exp_q.push_back(ref_rd(req_addr));
          exp_out++;
          rd_acc_cyc = cyc;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 72'(rsp_valid), 72'(0));
        end else begin
          w = exp_q.pop_front();
          check("rsp_data", rsp_data, w);
          exp_out--;
        end
        if (pop_cnt == 0) first_pop = cyc;
        else if (cyc - last_pop > max_gap) max_gap = cyc - last_pop;
        last_pop = cyc;
        pop_cnt++;
        last_pop_data = rsp_data;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [8:0] bwe, input logic [71:0] data);
    int start;
    int n;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_bwe   = bwe;
    req_data  = data;
    start     = acc_cnt;
    n         = 0;
    while (acc_cnt == start && n < 200) begin
      step();
      n++;
    end
    check("send_accept", 72'(acc_cnt - start), 72'(1));
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain_empty", 72'(exp_q.size()), 72'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [71:0] D1 = 72'h12_3456789A_BCDEF012;

  initial begin
    int base;
    errors = 0; checks = 0; cyc = 0; exp_out = 0;
    acc_cnt = 0; pop_cnt = 0; max_gap = 0; rd_acc_cyc = 0; first_pop = 0; last_pop = 0;
    last_pop_data = '0; rnd_rdy = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_bwe = '0;
    req_data = '0; rsp_ready = 1'b0;

    // Reset values
    step(); step();
    check("rst_en", 72'(URAM_EN), 72'(0));
    check("rst_rdb_wr", 72'(URAM_RDB_WR), 72'(0));
    check("rst_addr", 72'(URAM_ADDR), 72'(0));
    check("rst_bwe", 72'(URAM_BWE), 72'(0));
    check("rst_din", URAM_DIN, 72'(0));
    check("rst_rsp_valid", 72'(rsp_valid), 72'(0));
    check("rst_rsp_data", rsp_data, 72'(0));
    check("rst_outstanding", 72'(rd_outstanding), 72'(0));
    rst = 1'b0;
    step();

    // Write then read same address, latency and issue encoding
    rsp_ready = 1'b1;
    send(1'b1, 16'h0005, 9'h1FF, D1);
    check("wr_en", 72'(URAM_EN), 72'(1));
    check("wr_rdb_wr", 72'(URAM_RDB_WR), 72'(1));
    check("wr_addr", 72'(URAM_ADDR), 72'(5));
    check("wr_bwe", 72'(URAM_BWE), 72'h1FF);
    check("wr_din", URAM_DIN, D1);
    send(1'b0, 16'h0005, 9'h1FF, 72'h55);
    check("rd_en", 72'(URAM_EN), 72'(1));
    check("rd_rdb_wr", 72'(URAM_RDB_WR), 72'(0));
    check("rd_addr", 72'(URAM_ADDR), 72'(5));
    check("rd_bwe", 72'(URAM_BWE), 72'(0));
    check("rd_din", URAM_DIN, 72'(0));
    step();
    check("idle_en", 72'(URAM_EN), 72'(0));
    check("idle_bwe", 72'(URAM_BWE), 72'(0));
    for (int n = 0; n < 20 && !rsp_valid; n++) step();
    check("rsp_seen", 72'(rsp_valid), 72'(1));
    check("rd_latency", 72'(cyc - rd_acc_cyc), 72'(RD_LAT + 2));
    step();
    check("raw_data", last_pop_data, D1);
    step(); step();
    check("outstanding_idle", 72'(rd_outstanding), 72'(0));

    // Credit back-pressure with a stalled consumer
    for (int i = 0; i < 6; i++) send(1'b1, 16'(16'h20 + i), 9'h1FF, 72'(32'h200 + i));
    rsp_ready = 1'b0;
    base = acc_cnt;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h20;
    for (int i = 0; i < 12; i++) begin
      step();
      req_addr = 16'(16'h20 + (acc_cnt - base));
    end
    check("stall_accepts", 72'(acc_cnt - base), 72'(RSP_DEPTH));
    check("stall_outstanding", 72'(rd_outstanding), 72'(RSP_DEPTH));
    check("stall_rd_ready", 72'(req_ready), 72'(0));
    req_valid = 1'b0; req_wr = 1'b1;
    #1;
    check("stall_wr_ready", 72'(req_ready), 72'(1));
    send(1'b1, 16'h0030, 9'h1FF, 72'hABC);
    base = pop_cnt;
    rsp_ready = 1'b1;
    send(1'b0, 16'h0024, 9'h0, 72'h0);
    send(1'b0, 16'h0025, 9'h0, 72'h0);
    drain();
    check("stall_pops", 72'(pop_cnt - base), 72'(6));
    check("stall_last", last_pop_data, 72'h205);

    // Stream across the bank boundary
    for (int k = 0; k < 16; k++) send(1'b1, 16'(16'h0FF8 + k), 9'h1FF, 72'(k));
    pop_cnt = 0; max_gap = 0;
    for (int k = 0; k < 16; k++) send(1'b0, 16'(16'h0FF8 + k), 9'h0, 72'h0);
    drain();
    check("stream_pops", 72'(pop_cnt), 72'(16));
    check("stream_gap", 72'(max_gap <= 2), 72'(1));
    check("stream_last", last_pop_data, 72'(15));

    // Random mixed traffic with random consumer stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 9'($urandom),
           72'({$urandom, $urandom, $urandom}));
    end
    rnd_rdy = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset with reads in the FIFO and in flight
    rsp_ready = 1'b0;
    send(1'b0, 16'h0020, 9'h0, 72'h0);
    send(1'b0, 16'h0021, 9'h0, 72'h0);
    for (int n = 0; n < 6; n++) step();
    check("pre_rst_valid", 72'(rsp_valid), 72'(1));
    send(1'b0, 16'h0022, 9'h0, 72'h0);
    send(1'b0, 16'h0023, 9'h0, 72'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_rsp_valid", 72'(rsp_valid), 72'(0));
    check("midrst_outstanding", 72'(rd_outstanding), 72'(0));
    check("midrst_en", 72'(URAM_EN), 72'(0));
    rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      check("no_stale_rsp", 72'(rsp_valid), 72'(0));
    end

    // Partial byte write
    send(1'b1, 16'h0005, 9'h1FF, D1);
    send(1'b1, 16'h0005, 9'h001, 72'hFF);
    send(1'b0, 16'h0005, 9'h0, 72'h0);
    drain();
    check("partial_write", last_pop_data, 72'h12_3456789A_BCDEF0FF);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
